// File: rtl/debugger_pkg.sv
// Shared definitions for the UART debugger: TX FSM state encoding, default frame
// header and the command codes exchanged with the receive half.
package debugger_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_HEADER   = 3'd1;
    localparam state_t ST_PAYLOAD  = 3'd2;
    localparam state_t ST_CHECKSUM = 3'd3;
    localparam state_t ST_DONE     = 3'd4;

    localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

    localparam logic [1:0] CMD_STEP    = 2'b01;
    localparam logic [1:0] CMD_RUN_ALL = 2'b10;
    localparam logic [1:0] CMD_RESET   = 2'b11;

endpackage

// File: rtl/tx_byte_select.sv
// Picks one byte of the latched snapshot by index; byte 0 is bits [7:0].
module tx_byte_select #(
    parameter int FRAME_BYTES = 16,
    parameter int CNT_W       = 4
) (
    input  logic [FRAME_BYTES*8-1:0] snapshot,
    input  logic [CNT_W-1:0]         sel,
    output logic [7:0]               byte_out
);

    logic [7:0] frame_bytes [FRAME_BYTES];

    generate
        for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_bytes
            assign frame_bytes[gi] = snapshot[gi*8 +: 8];
        end
    endgenerate

    // Compare-based mux so a non power-of-two FRAME_BYTES never indexes out of range.
    always_comb begin
        byte_out = 8'h00;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            if (sel == CNT_W'(i)) begin
                byte_out = frame_bytes[i];
            end
        end
    end

endmodule

// File: rtl/debugger_tx.sv
// Debugger transmit half: latches a pipeline snapshot on request and writes it to the
// UART TX FIFO as header, payload bytes and an XOR checksum, then pulses data_sent.
module debugger_tx
    import debugger_pkg::*;
#(
    parameter int         FRAME_BYTES = 16,
    parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER_BYTE,
    parameter int         CNT_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1
) (
    input  logic                     clk,
    input  logic                     global_reset,
    input  logic                     send_data,
    input  logic [FRAME_BYTES*8-1:0] frame_data,
    input  logic                     tx_full,
    output logic [7:0]               w_data,
    output logic                     wr_uart,
    output logic                     data_sent,
    output logic                     busy
);

    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         counter_reg, counter_next;
    logic [7:0]               checksum_reg, checksum_next;
    logic [FRAME_BYTES*8-1:0] snapshot_reg, snapshot_next;
    logic [7:0]               payload_byte;
    logic                     last_byte;

    tx_byte_select #(
        .FRAME_BYTES (FRAME_BYTES),
        .CNT_W       (CNT_W)
    ) u_byte_select (
        .snapshot (snapshot_reg),
        .sel      (counter_reg),
        .byte_out (payload_byte)
    );

    assign last_byte = (counter_reg == CNT_W'(FRAME_BYTES - 1));
    assign busy      = (state_reg != ST_IDLE);

    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            state_reg    <= ST_IDLE;
            counter_reg  <= '0;
            checksum_reg <= '0;
            snapshot_reg <= '0;
        end else begin
            state_reg    <= state_next;
            counter_reg  <= counter_next;
            checksum_reg <= checksum_next;
            snapshot_reg <= snapshot_next;
        end
    end

    // A byte is consumed only when the FIFO accepts it; otherwise everything holds.
    always_comb begin
        state_next    = state_reg;
        counter_next  = counter_reg;
        checksum_next = checksum_reg;
        snapshot_next = snapshot_reg;
        wr_uart       = 1'b0;
        data_sent     = 1'b0;
        w_data        = 8'h00;
        case (state_reg)
            ST_IDLE: begin
                if (send_data) begin
                    snapshot_next = frame_data;
                    counter_next  = '0;
                    checksum_next = '0;
                    state_next    = ST_HEADER;
                end
            end
            ST_HEADER: begin
                wr_uart = !tx_full;
                w_data  = HEADER_BYTE;
                if (!tx_full) begin
                    checksum_next = checksum_reg ^ HEADER_BYTE;
                    state_next    = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                wr_uart = !tx_full;
                w_data  = payload_byte;
                if (!tx_full) begin
                    checksum_next = checksum_reg ^ payload_byte;
                    if (last_byte) begin
                        state_next = ST_CHECKSUM;
                    end else begin
                        counter_next = counter_reg + CNT_W'(1);
                    end
                end
            end
            ST_CHECKSUM: begin
                wr_uart = !tx_full;
                w_data  = checksum_reg;
                if (!tx_full) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                data_sent  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_debugger_tx.sv
// Directed bench for debugger_tx with a 4-byte frame: framing, back-pressure,
// snapshot stability, ignored requests, mid-frame reset and a command loop.
module tb_debugger_tx;

    localparam int FB = 4;

    logic          clk;
    logic          global_reset;
    logic          send_data;
    logic [FB*8-1:0] frame_data;
    logic          tx_full;
    logic [7:0]    w_data;
    logic          wr_uart;
    logic          data_sent;
    logic          busy;

    int tests;
    int fails;

    logic [7:0] wq[$];
    int         wc[$];
    int         dq[$];
    logic       wr_h   [0:31];
    logic [7:0] wd_h   [0:31];
    logic       busy_h [0:31];

    debugger_tx #(.FRAME_BYTES(FB)) dut (
        .clk          (clk),
        .global_reset (global_reset),
        .send_data    (send_data),
        .frame_data   (frame_data),
        .tx_full      (tx_full),
        .w_data       (w_data),
        .wr_uart      (wr_uart),
        .data_sent    (data_sent),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses send_data in cycle 0, then samples cycles 1..ncyc recording every write.
    task automatic run_frame(input logic [31:0] fd, input int stall_at, input int stall_len,
                             input int resend_at, input logic change_fd, input int ncyc);
        wq.delete();
        wc.delete();
        dq.delete();
        @(posedge clk); #1;
        frame_data = fd;
        send_data  = 1'b1;
        tx_full    = 1'b0;
        @(posedge clk); #1;
        send_data = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            send_data = (c == resend_at);
            tx_full   = (c >= stall_at) && (c < stall_at + stall_len);
            if (change_fd && c == 1) frame_data = 32'hDEADBEEF;
            #1;
            wr_h[c]   = wr_uart;
            wd_h[c]   = w_data;
            busy_h[c] = busy;
            if (wr_uart) begin
                wq.push_back(w_data);
                wc.push_back(c);
            end
            if (data_sent) dq.push_back(c);
        end
        send_data = 1'b0;
        tx_full   = 1'b0;
        $display("[TB] frame %h: %0d writes, %0d data_sent pulses, first at cycle %0d",
                 fd, wq.size(), dq.size(), (dq.size() > 0) ? dq[0] : -1);
    endtask

    task automatic test_reset();
        global_reset = 1'b0;
        send_data    = 1'b0;
        tx_full      = 1'b0;
        frame_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (wr_uart !== 1'b0) begin fails++; $display("FAIL reset_wr_uart got %b want 0", wr_uart); end
        tests++;
        if (data_sent !== 1'b0) begin fails++; $display("FAIL reset_data_sent got %b want 0", data_sent); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++;
        if (w_data !== 8'h00) begin fails++; $display("FAIL reset_w_data got %h want 00", w_data); end
        global_reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [6] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hE1};
        run_frame(32'h44332211, 0, 0, 0, 1'b0, 9);
        tests++;
        if (wq.size() != 6) begin fails++; $display("FAIL basic_count got %0d want 6", wq.size()); end
        for (int i = 0; i < 6 && i < wq.size(); i++) begin
            tests++;
            if (wq[i] !== exp_b[i] || wc[i] != i + 1) begin
                fails++;
                $display("FAIL basic_byte%0d got %h@%0d want %h@%0d", i, wq[i], wc[i], exp_b[i], i + 1);
            end
        end
        tests++;
        if (dq.size() != 1 || dq[0] != 7) begin
            fails++;
            $display("FAIL basic_data_sent got %0d pulses first %0d want 1 at 7", dq.size(),
                     (dq.size() > 0) ? dq[0] : -1);
        end
        for (int c = 1; c <= 9; c++) begin
            tests++;
            if (busy_h[c] !== (c <= 7)) begin
                fails++;
                $display("FAIL basic_busy_c%0d got %b want %b", c, busy_h[c], (c <= 7));
            end
        end
        tests++;
        if (wd_h[8] !== 8'h00 || wr_h[8] !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle_out got wr=%b data=%h want wr=0 data=00", wr_h[8], wd_h[8]);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] exp_b [6] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hE1};
        int         exp_c [6] = '{1, 2, 6, 7, 8, 9};
        run_frame(32'h44332211, 3, 3, 0, 1'b0, 12);
        tests++;
        if (wq.size() != 6) begin fails++; $display("FAIL bp_count got %0d want 6", wq.size()); end
        for (int i = 0; i < 6 && i < wq.size(); i++) begin
            tests++;
            if (wq[i] !== exp_b[i] || wc[i] != exp_c[i]) begin
                fails++;
                $display("FAIL bp_byte%0d got %h@%0d want %h@%0d", i, wq[i], wc[i], exp_b[i], exp_c[i]);
            end
        end
        for (int c = 3; c <= 5; c++) begin
            tests++;
            if (wr_h[c] !== 1'b0 || wd_h[c] !== 8'h22) begin
                fails++;
                $display("FAIL bp_stall_c%0d got wr=%b data=%h want wr=0 data=22", c, wr_h[c], wd_h[c]);
            end
        end
        tests++;
        if (dq.size() != 1 || dq[0] != 10) begin
            fails++;
            $display("FAIL bp_data_sent got %0d pulses first %0d want 1 at 10", dq.size(),
                     (dq.size() > 0) ? dq[0] : -1);
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] exp_b [6] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hE1};
        run_frame(32'h44332211, 0, 0, 0, 1'b1, 9);
        tests++;
        if (wq.size() != 6) begin fails++; $display("FAIL snap_count got %0d want 6", wq.size()); end
        for (int i = 0; i < 6 && i < wq.size(); i++) begin
            tests++;
            if (wq[i] !== exp_b[i]) begin
                fails++;
                $display("FAIL snap_byte%0d got %h want %h", i, wq[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_busy_request();
        run_frame(32'h44332211, 0, 0, 3, 1'b0, 14);
        tests++;
        if (wq.size() != 6) begin fails++; $display("FAIL busyreq_writes got %0d want 6", wq.size()); end
        tests++;
        if (dq.size() != 1) begin fails++; $display("FAIL busyreq_pulses got %0d want 1", dq.size()); end
        tests++;
        if (busy_h[14] !== 1'b0) begin fails++; $display("FAIL busyreq_idle got busy=%b want 0", busy_h[14]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b [6] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
        int         ds_seen = 0;
        @(posedge clk); #1;
        frame_data = 32'h44332211;
        send_data  = 1'b1;
        @(posedge clk); #1;
        send_data = 1'b0;
        // cycles 1..3: header, 11, 22
        repeat (3) @(posedge clk);
        #1;
        global_reset = 1'b0;
        #1;
        tests++;
        if (wr_uart !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_immediate got wr=%b busy=%b want 0 0", wr_uart, busy);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (data_sent) ds_seen++;
        end
        global_reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (data_sent) ds_seen++;
        end
        tests++;
        if (ds_seen != 0) begin fails++; $display("FAIL rstmid_no_sent got %0d pulses want 0", ds_seen); end
        run_frame(32'h00000000, 0, 0, 0, 1'b0, 8);
        tests++;
        if (wq.size() != 6) begin fails++; $display("FAIL rstmid_count got %0d want 6", wq.size()); end
        for (int i = 0; i < 6 && i < wq.size(); i++) begin
            tests++;
            if (wq[i] !== exp_b[i]) begin
                fails++;
                $display("FAIL rstmid_byte%0d got %h want %h", i, wq[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_loop();
        logic [1:0]  cmds   [2] = '{2'b01, 2'b11};
        logic [31:0] frames [2] = '{32'h04030201, 32'h80402010};
        logic [7:0]  sums   [2] = '{8'hA1, 8'h55};
        for (int k = 0; k < 2; k++) begin
            run_frame(frames[k], 0, 0, 0, 1'b0, 8);
            tests++;
            if (wq.size() != FB + 2 || dq.size() != 1) begin
                fails++;
                $display("FAIL loop_cmd%b got %0d writes %0d pulses want 6 1", cmds[k], wq.size(), dq.size());
            end
            tests++;
            if (wq.size() == FB + 2 && (wq[0] !== 8'hA5 || wq[1] !== frames[k][7:0] || wq[FB] !== frames[k][31:24]
                                        || wq[FB + 1] !== sums[k])) begin
                fails++;
                $display("FAIL loop_cmd%b_bytes got %h %h %h %h want a5 %h %h %h", cmds[k], wq[0], wq[1], wq[FB],
                         wq[FB + 1], frames[k][7:0], frames[k][31:24], sums[k]);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_back_pressure();
        test_snapshot();
        test_busy_request();
        test_reset_mid();
        test_loop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
